// File: rtl/stopwatch_pkg.sv
// stopwatch_pkg: shared segment patterns, slot index type and anode constants for the display path
package stopwatch_pkg;
    typedef logic [1:0] slot_t;
    localparam logic [6:0] SEG_0    = 7'b1000000;
    localparam logic [6:0] SEG_1    = 7'b1111001;
    localparam logic [6:0] SEG_2    = 7'b0100100;
    localparam logic [6:0] SEG_3    = 7'b0110000;
    localparam logic [6:0] SEG_4    = 7'b0011001;
    localparam logic [6:0] SEG_5    = 7'b0010010;
    localparam logic [6:0] SEG_6    = 7'b0000010;
    localparam logic [6:0] SEG_7    = 7'b1111000;
    localparam logic [6:0] SEG_8    = 7'b0000000;
    localparam logic [6:0] SEG_9    = 7'b0010000;
    localparam logic [6:0] SEG_DASH = 7'b0111111;
    localparam logic [6:0] SEG_OFF  = 7'b1111111;
    localparam logic [3:0] AN_OFF   = 4'b1111;
endpackage

// File: rtl/seg_display_mux_if.sv
// seg_display_mux_if: digit/blink inputs and active-low display drive of the scan multiplexer
interface seg_display_mux_if;
    logic [4:0] min_l;
    logic [4:0] min_r;
    logic [4:0] sec_l;
    logic [4:0] sec_r;
    logic       blink_en;
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
    modport master (output min_l, min_r, sec_l, sec_r, blink_en, input an, seg, dp);
    modport slave  (input min_l, min_r, sec_l, sec_r, blink_en, output an, seg, dp);
endinterface

// File: rtl/bcd_to_seg.sv
// bcd_to_seg: 5-bit digit to active-low {g,f,e,d,c,b,a} pattern, dash for anything above 9
module bcd_to_seg
    import stopwatch_pkg::*;
(
    input  logic [4:0] d,
    output logic [6:0] seg
);
    always_comb begin
        seg = SEG_DASH;
        case (d)
            5'd0:    seg = SEG_0;
            5'd1:    seg = SEG_1;
            5'd2:    seg = SEG_2;
            5'd3:    seg = SEG_3;
            5'd4:    seg = SEG_4;
            5'd5:    seg = SEG_5;
            5'd6:    seg = SEG_6;
            5'd7:    seg = SEG_7;
            5'd8:    seg = SEG_8;
            5'd9:    seg = SEG_9;
            default: seg = SEG_DASH;
        endcase
    end
endmodule

// File: rtl/seg_display_mux.sv
// seg_display_mux: scans four digits onto a common-anode display with frame snapshot, lead blank and blink
module seg_display_mux
    import stopwatch_pkg::*;
#(
    parameter int SCAN_DIV     = 100000,
    parameter int BLINK_FRAMES = 125,
    parameter int BLANK_LEAD   = 1
) (
    input logic             clk,
    input logic             rst_n,
    seg_display_mux_if.slave bus
);
    localparam int PW = $clog2(SCAN_DIV);
    localparam int FW = BLINK_FRAMES > 1 ? $clog2(BLINK_FRAMES) : 1;

    logic [PW-1:0] pre;
    slot_t         slot, nslot;
    logic [4:0]    din [4];
    logic [4:0]    shadow [4];
    logic [FW-1:0] fcnt;
    logic          phase, lit, next_lit;
    logic          tc, wrap, last, blink_off, lead_off;
    logic [4:0]    digit;
    logic [6:0]    seg_d;

    always_comb begin
        din[0] = bus.sec_r;
        din[1] = bus.sec_l;
        din[2] = bus.min_r;
        din[3] = bus.min_l;
    end

    assign tc    = pre == PW'(SCAN_DIV - 1);
    assign nslot = slot + 2'd1;
    assign wrap  = slot == 2'd3;
    assign last  = fcnt == FW'(BLINK_FRAMES - 1);
    // slot 0 of a new frame shows the inputs being captured on this very edge
    assign digit = wrap ? bus.sec_r : shadow[nslot];
    // lit holds the phase of the frame in progress so a toggle never splits a frame
    assign next_lit  = wrap ? phase : lit;
    assign blink_off = bus.blink_en && !next_lit;
    assign lead_off  = BLANK_LEAD != 0 && nslot == 2'd3 && shadow[3] == 5'd0;

    bcd_to_seg u_dec (.d(digit), .seg(seg_d));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre     <= '0;
            slot    <= '0;
            shadow  <= '{default: '0};
            fcnt    <= '0;
            phase   <= 1'b1;
            lit     <= 1'b1;
            bus.an  <= 4'b1110;
            bus.seg <= SEG_0;
            bus.dp  <= 1'b1;
        end else begin
            pre <= tc ? '0 : pre + PW'(1);
            if (tc) begin
                slot <= nslot;
                if (wrap) shadow <= din;
                if (!bus.blink_en) begin
                    fcnt  <= '0;
                    phase <= 1'b1;
                    lit   <= 1'b1;
                end else if (wrap) begin
                    lit   <= phase;
                    fcnt  <= last ? '0 : fcnt + FW'(1);
                    phase <= last ? !phase : phase;
                end
                bus.an  <= (blink_off || lead_off) ? AN_OFF : ~(4'b0001 << nslot);
                bus.seg <= (blink_off || lead_off) ? SEG_OFF : seg_d;
                bus.dp  <= blink_off || nslot != 2'd2;
            end
        end
    end
endmodule

// File: doc/seg_display_mux.md
Name: seg_display_mux

Overview:
- Downstream consumer of the stopwatch digit counter.
- Takes the four 5-bit digit values (minutes tens/ones, seconds tens/ones) and time-multiplexes them onto a 4-digit common-anode 7-segment display.
- Drives active-low anodes, cathodes and decimal point.
- Optionally blinks the display (e.g. while paused) and blanks a leading zero in the minutes-tens position.

Parameters:
- SCAN_DIV, 100000: clk cycles per digit slot (1 kHz slot rate at 100 MHz); must be >= 2.
- BLINK_FRAMES, 125: full 4-slot frames per blink half-period (0.5 s at defaults).
- BLANK_LEAD, 1: 1 = blank min_l when it is 0; 0 = always show it.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- min_l  in  5  minutes tens digit, binary 0..9 valid.
- min_r  in  5  minutes ones digit.
- sec_l  in  5  seconds tens digit.
- sec_r  in  5  seconds ones digit.
- blink_en  in  1  1 = blink whole display at the BLINK_FRAMES rate.
- an  out  4  anode enables, active-low; an[0] = rightmost digit (sec_r).
- seg  out  7  cathodes, active-low, bit order {g,f,e,d,c,b,a}.
- dp  out  1  decimal point, active-low.

Behaviour:
- Prescaler counts 0..SCAN_DIV-1 and wraps. Terminal count (TC) = prescaler at SCAN_DIV-1.
- Slot counter 0..3. It advances by 1 on each TC edge and wraps 3->0.
- Slot-to-digit mapping: 0 = sec_r, 1 = sec_l, 2 = min_r, 3 = min_l.
- an, seg and dp are registered. On each TC edge they update in the same edge as the slot counter, to the values for the new slot. No other edge changes them, apart from reset.
- Frame snapshot:
  - On the TC edge where slot wraps 3->0, all four digit inputs are captured into shadow registers.
  - Slot 0 of the new frame is decoded from the inputs on that same edge, which are the values being captured.
  - Slots 1..3 are decoded from the shadow registers.
  - Effect: no tearing inside a frame.
- Decode:
  - 0..9 gives standard patterns. 0 = 1000000, 1 = 1111001, 8 = 0000000.
  - Any value 10..31 shows a dash, 0111111.
- dp = 0 only while slot 2 is shown (minutes/seconds separator); 1 otherwise.
- Leading blank: if BLANK_LEAD = 1, slot 3 and shadow min_l == 0, then an = 1111 and seg = 1111111 for that slot. dp is unaffected, since it is already 1 in slot 3.
- Blink:
  - A frame counter (0..BLINK_FRAMES-1) increments on each 3->0 wrap. On reaching terminal count it wraps and toggles a phase bit (1 = on).
  - If blink_en = 1 and phase = 0, then an = 1111, seg = 1111111 and dp = 1. Prescaler and slot keep running.
  - While blink_en = 0, the frame counter is held at 0 and phase at 1.
  - After blink_en rises, the display therefore stays lit for BLINK_FRAMES full frames before the first off phase.
  - blink_en is sampled on TC edges only.
- Reset (rst_n low, asynchronous):
  - prescaler = 0, slot = 0, shadow digits = 0, frame counter = 0, phase = 1.
  - an = 1110, seg = 1000000, dp = 1.
  - Reset asserted mid-slot takes effect immediately.
  - On release, the first TC occurs SCAN_DIV cycles later.
- Latency: a digit change reaches the display at the next 3->0 wrap. Worst case is 4*SCAN_DIV cycles.
- Exactly one anode is low at any time, except when blanked by the leading-blank or blink rules, in which case none is low.

Decomposition:
- Shared package (stopwatch_pkg):
  - segment pattern constants SEG_0..SEG_9, SEG_DASH, SEG_OFF;
  - a slot index typedef (2-bit);
  - the anode-off constant 4'b1111.
- Sub-module bcd_to_seg: purely combinational, 5-bit in, 7-bit active-low out, with dash for values >9. It is instantiated once on the muxed digit.

Test Plan:
- Reset with SCAN_DIV = 4, inputs 1,2,3,4 (min_l..sec_r) -> during rst_n low: an = 1110, seg = 1000000, dp = 1. First TC 4 cycles after release -> an = 1101. The first frame shows shadow values (0), so seg = 1000000.
- Steady scan with inputs 0,5,3,7 and BLANK_LEAD = 1 after one full frame:
  - slot 0: an = 1110, seg = SEG_7;
  - slot 1: an = 1101, seg = SEG_3;
  - slot 2: an = 1011, seg = SEG_5, dp = 0;
  - slot 3: an = 1111 (leading zero blanked).
- Snapshot/no tearing: change sec_l 3->4 while slot 2 is displayed -> slot 1 keeps showing 3 in the current frame and shows 4 only after the next 3->0 wrap.
- Invalid digit: sec_r = 12 -> slot 0 seg = 0111111. Set BLANK_LEAD = 0 with min_l = 0 -> slot 3 shows SEG_0 with an = 0111.
- Blink with BLINK_FRAMES = 2 and blink_en = 1 -> 2 frames lit, 2 frames with an = 1111 and dp = 1, then repeating. Dropping blink_en mid-off-phase -> display lit from the next TC edge.
- Async reset mid-slot with rst_n pulsed low between clock edges -> outputs go to reset values immediately, without waiting for a clk edge.
